// File: rtl/fp_div_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_div_seq_if
//  Purpose  : Handshake bundle for the sequential floating-point divider.
//             Operand channel (in_valid/in_ready, a, b) and result channel
//             (out_valid/out_ready, q, div_by_zero, invalid).
//  Ports    : master - producer of operands / consumer of results
//             slave  - the divider itself
//  Revision : 1.0  initial release
// ============================================================================
interface fp_div_seq_if #(
   parameter int NEXP = 8,
   parameter int NSIG = 7
);
   localparam int W = 1 + NEXP + NSIG;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  q;
   logic          div_by_zero;
   logic          invalid;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, q, div_by_zero, invalid
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, q, div_by_zero, invalid
   );
endinterface
`default_nettype wire

// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_div_seq
//  Purpose  : Sequential floating-point divider {sign, exp, frac}, no
//             denormals, truncating rounding. Restoring division produces
//             one quotient bit per cycle; special operands bypass the
//             iteration and complete in the cycle after accept.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - fp_div_seq_if.slave (operand and result handshakes)
//  Revision : 1.0  initial release
// ============================================================================
module fp_div_seq #(
   parameter int NEXP = 8,
   parameter int NSIG = 7
) (
   input  logic        clk,
   input  logic        rst,
   fp_div_seq_if.slave bus
);
   localparam int W  = 1 + NEXP + NSIG;
   localparam int EW = NEXP + 2;          // signed exponent working width
   localparam int RW = NSIG + 3;          // remainder width
   localparam int QW = NSIG + 2;          // quotient width, Q1.(NSIG+1)
   localparam int CW = $clog2(NSIG + 3);  // iteration counter width

   localparam logic [CW-1:0]        C_LAST = CW'(NSIG + 1);
   localparam logic signed [EW-1:0] C_BIAS = EW'((1 << (NEXP - 1)) - 1);
   localparam logic signed [EW-1:0] C_EMAX = EW'((1 << NEXP) - 1);
   localparam logic signed [EW-1:0] C_EZERO = '0;
   localparam logic signed [EW-1:0] C_ONE  = EW'(1);
   localparam logic [W-1:0]         C_NAN  = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_NORM = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      state_q, state_d;
   logic            sign_q;
   logic [NEXP-1:0] ea_q, eb_q;
   logic [NSIG:0]   mb_q;
   logic [RW-1:0]   rem_q, rem_d;
   logic [QW-1:0]   quo_q, quo_d;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    q_q;
   logic            dbz_q, inv_q;

   // ------------------------------------------------------------------------
   // Operand decode
   // ------------------------------------------------------------------------
   logic            w_a_sign, w_b_sign;
   logic [NEXP-1:0] w_a_exp, w_b_exp;
   logic [NSIG-1:0] w_a_frac, w_b_frac;
   logic            w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic            w_special, w_accept, w_res_sign;

   assign {w_a_sign, w_a_exp, w_a_frac} = bus.a;
   assign {w_b_sign, w_b_exp, w_b_frac} = bus.b;

   assign w_a_zero = (w_a_exp == '0);
   assign w_b_zero = (w_b_exp == '0);
   assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
   assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
   assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
   assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);

   assign w_special  = w_a_zero || w_b_zero || (&w_a_exp) || (&w_b_exp);
   assign w_accept   = bus.in_valid && (state_q == S_IDLE);
   assign w_res_sign = w_a_sign ^ w_b_sign;

   // Special-case result, resolved in priority order
   logic [W-1:0] w_sp_q;
   logic         w_sp_dbz, w_sp_inv;

   always_comb begin
      w_sp_q   = {w_res_sign, {(W-1){1'b0}}};
      w_sp_dbz = 1'b0;
      w_sp_inv = 1'b0;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_sp_q   = C_NAN;
         w_sp_inv = 1'b1;
      end else if (w_b_zero) begin
         w_sp_q   = {w_res_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
         w_sp_dbz = !w_a_inf;
      end else if (w_a_inf) begin
         w_sp_q   = {w_res_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      end
   end

   // ------------------------------------------------------------------------
   // Restoring division step
   // ------------------------------------------------------------------------
   logic [RW-1:0] w_mb_ext, w_rem_sub;
   logic          w_ge;

   assign w_mb_ext  = {2'b00, mb_q};
   assign w_ge      = (rem_q >= w_mb_ext);
   assign w_rem_sub = w_ge ? (rem_q - w_mb_ext) : rem_q;
   // The subtracted remainder is always below mb, so the shift never loses
   // a set bit.
   assign rem_d     = w_rem_sub << 1;
   assign quo_d     = {quo_q[QW-2:0], w_ge};

   // ------------------------------------------------------------------------
   // Normalisation and exponent range check
   // ------------------------------------------------------------------------
   logic signed [EW-1:0] w_e_raw, w_e_adj;
   logic [NSIG-1:0]      w_frac;
   logic [W-1:0]         w_norm_q;

   assign w_e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + C_BIAS;

   always_comb begin
      w_e_adj = w_e_raw;
      w_frac  = quo_q[NSIG:1];
      // Quotient below 1.0: the leading one sits one place lower
      if (!quo_q[QW-1]) begin
         w_e_adj = w_e_raw - C_ONE;
         w_frac  = quo_q[NSIG-1:0];
      end
   end

   always_comb begin
      if (w_e_adj >= C_EMAX) begin
         w_norm_q = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
      end else if (w_e_adj <= C_EZERO) begin
         w_norm_q = {sign_q, {(W-1){1'b0}}};
      end else begin
         w_norm_q = {sign_q, w_e_adj[NEXP-1:0], w_frac};
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) state_d = w_special ? S_DONE : S_DIV;
         S_DIV:  if (cnt_q == C_LAST) state_d = S_NORM;
         S_NORM: state_d = S_DONE;
         S_DONE: if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.in_ready  = (state_q == S_IDLE);
      bus.out_valid = (state_q == S_DONE);
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q <= 1'b0;
         ea_q   <= '0;
         eb_q   <= '0;
         mb_q   <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         q_q    <= '0;
         dbz_q  <= 1'b0;
         inv_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_accept) begin
                  sign_q <= w_res_sign;
                  ea_q   <= w_a_exp;
                  eb_q   <= w_b_exp;
                  mb_q   <= {1'b1, w_b_frac};
                  rem_q  <= {2'b00, 1'b1, w_a_frac};
                  quo_q  <= '0;
                  cnt_q  <= '0;
                  if (w_special) begin
                     q_q   <= w_sp_q;
                     dbz_q <= w_sp_dbz;
                     inv_q <= w_sp_inv;
                  end
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
            end
            S_NORM: begin
               q_q   <= w_norm_q;
               dbz_q <= 1'b0;
               inv_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.q           = q_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.invalid     = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_div_seq
//  Purpose  : Self-checking bench for fp_div_seq (NEXP=8, NSIG=7). Operands
//             are issued by a driver that pushes expected results into a
//             queue; a monitor pops and compares whenever a result appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_div_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   fp_div_seq_if #(.NEXP(8), .NSIG(7)) bus();
   fp_div_seq #(.NEXP(8), .NSIG(7)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] q;
      logic        dbz;
      logic        inv;
      int          lat;   // edges between accepting edge and first out_valid cycle
      int          acc;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic        dbz;
      logic        inv;
      int          lat;
   } dir_t;

   exp_t sb[$];
   exp_t cur;
   bit   have_cur = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   rdy_mode = 1;    // 0: out_ready low, 1: high, 2: random

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      bus.out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: classify operands, then plain integer division
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   ea, eb, fa, fb, qi, ex, fr;
      bit   az, ai, an, bz, bi, bn;
      logic s;
      e.dbz = 1'b0; e.inv = 1'b0; e.acc = 0; e.lat = 0;
      s  = a[15] ^ b[15];
      ea = int'(a[14:7]); fa = int'(a[6:0]);
      eb = int'(b[14:7]); fb = int'(b[6:0]);
      az = (ea == 0); ai = (ea == 255 && fa == 0); an = (ea == 255 && fa != 0);
      bz = (eb == 0); bi = (eb == 255 && fb == 0); bn = (eb == 255 && fb != 0);
      if (an || bn || (az && bz) || (ai && bi)) begin
         e.q = 16'h7FC0; e.inv = 1'b1;
      end else if (bz) begin
         e.q = {s, 8'hFF, 7'h00}; e.dbz = !ai;
      end else if (ai) begin
         e.q = {s, 8'hFF, 7'h00};
      end else if (az || bi) begin
         e.q = {s, 15'h0000};
      end else begin
         e.lat = 10;
         qi = ((128 + fa) * 256) / (128 + fb);   // truncated quotient, 2^8 scale
         ex = ea - eb + 127;
         if (qi >= 256) fr = (qi / 2) % 128;
         else begin fr = qi % 128; ex = ex - 1; end
         if (ex >= 255)     e.q = {s, 8'hFF, 7'h00};
         else if (ex <= 0)  e.q = {s, 15'h0000};
         else               e.q = {s, 8'(ex), 7'(fr)};
      end
      return e;
   endfunction

   function automatic logic [15:0] rand_word();
      int r, ex, fr;
      r  = $urandom_range(0, 9);
      fr = $urandom_range(0, 127);
      case (r)
         0: ex = 0;
         1: begin ex = 255; if ($urandom_range(0, 1) == 1) fr = 0; end
         2: ex = $urandom_range(1, 20);
         3: ex = $urandom_range(235, 254);
         default: ex = $urandom_range(100, 154);
      endcase
      return {1'($urandom_range(0, 1)), 8'(ex), 7'(fr)};
   endfunction

   // Monitor: compares every new result against the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk); #1;
         if (rst) begin
            have_cur = 1'b0;
         end else if (bus.out_valid) begin
            if (!have_cur) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
               end else begin
                  cur = sb.pop_front();
                  have_cur = 1'b1;
                  chk("q", 32'(bus.q), 32'(cur.q));
                  chk("div_by_zero", 32'(bus.div_by_zero), 32'(cur.dbz));
                  chk("invalid", 32'(bus.invalid), 32'(cur.inv));
                  chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
               end
            end else begin
               chk("q_stable", 32'(bus.q), 32'(cur.q));
               chk("flags_stable", {30'd0, bus.div_by_zero, bus.invalid}, {30'd0, cur.dbz, cur.inv});
            end
            if (have_cur && bus.out_ready) have_cur = 1'b0;
         end
      end
   end

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit push, input exp_t e);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      @(posedge clk); #1;
      e.acc = cyc;
      if (push) sb.push_back(e);
      bus.in_valid = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk); #1;
      while (!(bus.in_ready && !have_cur && sb.size() == 0) && t < 500) begin
         @(negedge clk); #1;
         t++;
      end
      if (t >= 500) chk("idle_timeout", 32'(sb.size()), 32'd0);
   endtask

   dir_t dir_tab[8];
   exp_t e;

   initial begin
      dir_tab[0] = '{16'h3F80, 16'h3F80, 16'h3F80, 1'b0, 1'b0, 10};
      dir_tab[1] = '{16'h4040, 16'h4000, 16'h3FC0, 1'b0, 1'b0, 10};
      dir_tab[2] = '{16'h3F80, 16'h4040, 16'h3EAA, 1'b0, 1'b0, 10};
      dir_tab[3] = '{16'h4000, 16'h0000, 16'h7F80, 1'b1, 1'b0, 0};
      dir_tab[4] = '{16'h0000, 16'h0000, 16'h7FC0, 1'b0, 1'b1, 0};
      dir_tab[5] = '{16'h7F00, 16'h3F00, 16'h7F80, 1'b0, 1'b0, 10};
      dir_tab[6] = '{16'h0080, 16'h4F80, 16'h0000, 1'b0, 1'b0, 10};
      dir_tab[7] = '{16'hC000, 16'h4000, 16'hBF80, 1'b0, 1'b0, 10};

      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_q", 32'(bus.q), 32'd0);
      chk("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      chk("rst_invalid", 32'(bus.invalid), 32'd0);
      rst = 1'b0;

      // Directed vectors with hand-derived results
      for (int i = 0; i < 8; i++) begin
         e.q = dir_tab[i].q; e.dbz = dir_tab[i].dbz; e.inv = dir_tab[i].inv;
         e.lat = dir_tab[i].lat; e.acc = 0;
         do_op(dir_tab[i].a, dir_tab[i].b, 1'b1, e);
      end
      wait_idle();

      // Back-pressure: result held while out_ready stays low
      rdy_mode = 0;
      e = model(16'h4040, 16'h4000);
      do_op(16'h4040, 16'h4000, 1'b1, e);
      begin
         int t;
         t = 0;
         while (!bus.out_valid && t < 50) begin @(negedge clk); #1; t++; end
         chk("stall_reach_done", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b1;
      bus.a = 16'h3F80;
      bus.b = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      end
      @(posedge clk); #1;
      rdy_mode = 1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("after_take_in_ready", 32'(bus.in_ready), 32'd1);
      chk("after_take_out_valid", 32'(bus.out_valid), 32'd0);

      // Reset in the 4th DIV cycle discards the operation
      wait_idle();
      e = model(16'h3F80, 16'h3F80);
      do_op(16'h3F80, 16'h3F80, 1'b0, e);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (15) @(negedge clk);
      e = model(16'h3F80, 16'h3F80);
      do_op(16'h3F80, 16'h3F80, 1'b1, e);
      wait_idle();

      // Randomised operands with random back-pressure
      rdy_mode = 2;
      for (int i = 0; i < 80; i++) begin
         logic [15:0] ra, rb;
         ra = rand_word();
         rb = rand_word();
         e = model(ra, rb);
         do_op(ra, rb, 1'b1, e);
      end
      rdy_mode = 1;
      wait_idle();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameter NEXP, default 8, exponent width; bias = 2^(NEXP-1)-1.
REQ-002 Parameter NSIG, default 7, stored fraction width; word width W = 1+NEXP+NSIG, laid out as {sign, exp, frac}.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operand pair a, b present.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  W  dividend.
REQ-008 b  in  W  divisor.
REQ-009 out_valid  out  1  result q and flags valid.
REQ-010 out_ready  in  1  consumer takes result.
REQ-011 q  out  W  quotient a/b.
REQ-012 div_by_zero  out  1  finite nonzero a divided by zero.
REQ-013 invalid  out  1  NaN operand, 0/0, or inf/inf.

Function
REQ-014 FSM states: IDLE, DIV, NORM, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Operand accept: in_valid && in_ready at edge k; a, b are captured; the result sign is sa XOR sb.
REQ-016 Operand classes: exp = 0 is zero (frac ignored, no denormals); exp all-ones with frac = 0 is inf; exp all-ones with frac != 0 is NaN.
REQ-017 Special cases, in priority order: any NaN, 0/0 or inf/inf gives canonical NaN {0, all-ones exp, frac MSB 1, rest 0} with invalid = 1; finite/0 gives signed inf with div_by_zero = 1; inf/0 or inf/finite gives signed inf; 0/nonzero or finite/inf gives signed zero.
REQ-018 Special cases go IDLE -> DONE at edge k, so out_valid is high in the cycle after edge k.
REQ-019 Normal operands: mantissas ma = {1, fa} and mb = {1, fb}; remainder register R is NSIG+3 bits wide and initialised to ma; IDLE -> DIV at edge k.
REQ-020 DIV runs restoring division, one quotient bit per cycle, MSB first, for exactly NSIG+2 cycles; each step: if R >= mb then the bit is 1 and R = R - mb, else the bit is 0; then R = R << 1.
REQ-021 Quotient Q is NSIG+2 bits in Q1.(NSIG+1) format, with value in (0.5, 2); after the last DIV step the FSM goes to NORM.
REQ-022 NORM exponent: E = ea - eb + bias, computed signed and at least NEXP+2 bits wide.
REQ-023 NORM fraction: if Q MSB = 1, frac = Q[NSIG:1]; otherwise frac = Q[NSIG-1:0] and E = E - 1.
REQ-024 Rounding is truncation (toward zero).
REQ-025 Exponent range: E >= 2^NEXP - 1 gives signed inf; E <= 0 gives signed zero; no flags are raised in either case.
REQ-026 NORM -> DONE registers q and flags; out_valid is high after edge k+NSIG+3 (10 cycles for the defaults).
REQ-027 DONE holds q and flags stable while out_ready = 0; out_valid && out_ready goes to IDLE, and in_ready = 1 in the next cycle; operands are never accepted in the same cycle a result is taken.
REQ-028 in_valid is ignored outside IDLE; a and b may change freely after the accept.

Reset
REQ-029 rst sampled high forces IDLE on that edge, from any state including mid-DIV; the in-flight operation is discarded.
REQ-030 Reset values: q = 0, div_by_zero = 0, invalid = 0, out_valid = 0, R = 0, Q = 0, iteration counter = 0; in_ready = 1 from the cycle after reset.

Verification
REQ-031 0x3F80/0x3F80 (1.0/1.0), out_ready = 1 -> q = 0x3F80, flags 0, out_valid exactly 10 cycles after accept.
REQ-032 0x4040/0x4000 (3/2) -> q = 0x3FC0; then 0x3F80/0x4040 (1/3) -> q = 0x3EAA (truncated, not 0x3EAB).
REQ-033 0x4000/0x0000 -> q = 0x7F80, div_by_zero = 1, out_valid 1 cycle after accept; 0x0000/0x0000 -> q = 0x7FC0, invalid = 1.
REQ-034 0x7F00/0x3F00 (2^127/0.5) -> q = 0x7F80, flags 0; 0x0080/0x4F80 -> q = 0x0000.
REQ-035 out_ready held low 5 cycles in DONE -> q stable, in_ready = 0, extra in_valid ignored; result taken on the first cycle with out_ready = 1.
REQ-036 rst pulsed 1 cycle in the 4th DIV cycle -> out_valid never rises for that operation; in_ready = 1 next cycle; a new 0x3F80/0x3F80 completes normally.
